// File: rtl/cc_flag_gen_pkg.sv
// Shared definitions for the branch-condition interface: ACC flag positions
// and condition-select encodings used by both producer and condition handler.
package cc_flag_gen_pkg;

    localparam int unsigned ACC_Z = 3;
    localparam int unsigned ACC_N = 2;
    localparam int unsigned ACC_C = 1;
    localparam int unsigned ACC_V = 0;

    typedef enum logic [2:0] {
        COND_EQ  = 3'd0,
        COND_NE  = 3'd1,
        COND_LT  = 3'd2,
        COND_GE  = 3'd3,
        COND_LTU = 3'd4,
        COND_GEU = 3'd5,
        COND_MI  = 3'd6,
        COND_PL  = 3'd7
    } cond_e;

    function automatic logic [3:0] acc_pack(input logic z, input logic n,
                                            input logic c, input logic v);
        logic [3:0] acc;
        acc        = '0;
        acc[ACC_Z] = z;
        acc[ACC_N] = n;
        acc[ACC_C] = c;
        acc[ACC_V] = v;
        return acc;
    endfunction

endpackage

// File: rtl/cc_flag_gen_if.sv
// Operand/sideband bundle in, aligned flags and sideband out, plus stage control.
interface cc_flag_gen_if #(parameter int unsigned W = 32);

    logic         in_valid;
    logic         in_bl;
    logic         in_comb;
    logic         in_comb_tf;
    logic [2:0]   in_c;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         stall;
    logic         flush;
    logic         out_valid;
    logic         BL;
    logic         COMB;
    logic         COMB_TF;
    logic [2:0]   C;
    logic [3:0]   ACC;
    logic         busy;

    modport master (
        output in_valid, in_bl, in_comb, in_comb_tf, in_c, in_a, in_b, stall, flush,
        input  out_valid, BL, COMB, COMB_TF, C, ACC, busy
    );

    modport slave (
        input  in_valid, in_bl, in_comb, in_comb_tf, in_c, in_a, in_b, stall, flush,
        output out_valid, BL, COMB, COMB_TF, C, ACC, busy
    );

endinterface

// File: rtl/cc_half_sub.sv
// Half-width adder with carry-in; subtraction is formed by the caller passing ~B.
module cc_half_sub #(
    parameter int unsigned H = 16
) (
    input  logic [H-1:0] a_i,
    input  logic [H-1:0] b_i,
    input  logic         ci_i,
    output logic [H-1:0] sum_o,
    output logic         co_o
);

    always_comb begin
        {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{H{1'b0}}, ci_i};
    end

endmodule

// File: rtl/cc_flag_gen.sv
// Two-stage A-B flag generator: S1 subtracts the low half, S2 the high half
// and registers {Z,N,C,V} together with the branch sideband.
module cc_flag_gen
    import cc_flag_gen_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    cc_flag_gen_if.slave    bus
);

    localparam int unsigned H = W / 2;

    logic         s1_valid_q, s1_valid_d;
    logic         s1_bl_q,    s1_bl_d;
    logic         s1_comb_q,  s1_comb_d;
    logic         s1_tf_q,    s1_tf_d;
    logic [2:0]   s1_c_q,     s1_c_d;
    logic [H-1:0] s1_ah_q,    s1_ah_d;
    logic [H-1:0] s1_bh_q,    s1_bh_d;
    logic         s1_cl_q,    s1_cl_d;
    logic         s1_zl_q,    s1_zl_d;

    logic         s2_valid_q, s2_valid_d;
    logic         s2_bl_q,    s2_bl_d;
    logic         s2_comb_q,  s2_comb_d;
    logic         s2_tf_q,    s2_tf_d;
    logic [2:0]   s2_c_q,     s2_c_d;
    logic [3:0]   s2_acc_q,   s2_acc_d;

    logic [H-1:0] lo_sum, hi_sum;
    logic         lo_co,  hi_co;

    cc_half_sub #(.H(H)) u_sub_lo (
        .a_i   (bus.in_a[H-1:0]),
        .b_i   (~bus.in_b[H-1:0]),
        .ci_i  (1'b1),
        .sum_o (lo_sum),
        .co_o  (lo_co)
    );

    // Low-half carry feeds the high half: the two halves form one W-bit subtract.
    cc_half_sub #(.H(H)) u_sub_hi (
        .a_i   (s1_ah_q),
        .b_i   (~s1_bh_q),
        .ci_i  (s1_cl_q),
        .sum_o (hi_sum),
        .co_o  (hi_co)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_bl_d    = s1_bl_q;
        s1_comb_d  = s1_comb_q;
        s1_tf_d    = s1_tf_q;
        s1_c_d     = s1_c_q;
        s1_ah_d    = s1_ah_q;
        s1_bh_d    = s1_bh_q;
        s1_cl_d    = s1_cl_q;
        s1_zl_d    = s1_zl_q;
        if (bus.flush) begin
            s1_valid_d = 1'b0;
        end else if (!bus.stall) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_bl_d   = bus.in_bl;
                s1_comb_d = bus.in_comb;
                s1_tf_d   = bus.in_comb_tf;
                s1_c_d    = bus.in_c;
                s1_ah_d   = bus.in_comb ? bus.in_a[W-1:H] : '0;
                s1_bh_d   = bus.in_comb ? bus.in_b[W-1:H] : '0;
                s1_cl_d   = bus.in_comb & lo_co;
                s1_zl_d   = bus.in_comb & (lo_sum == '0);
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_bl_d    = s2_bl_q;
        s2_comb_d  = s2_comb_q;
        s2_tf_d    = s2_tf_q;
        s2_c_d     = s2_c_q;
        s2_acc_d   = s2_acc_q;
        if (bus.flush || (!bus.stall && !s1_valid_q)) begin
            s2_valid_d = 1'b0;
            s2_bl_d    = 1'b0;
            s2_comb_d  = 1'b0;
            s2_tf_d    = 1'b0;
            s2_c_d     = '0;
            s2_acc_d   = '0;
        end else if (!bus.stall) begin
            s2_valid_d = 1'b1;
            s2_bl_d    = s1_bl_q;
            s2_comb_d  = s1_comb_q;
            s2_tf_d    = s1_tf_q;
            s2_c_d     = s1_c_q;
            s2_acc_d   = s1_comb_q
                       ? acc_pack(s1_zl_q & (hi_sum == '0),
                                  hi_sum[H-1],
                                  ~hi_co,
                                  (s1_ah_q[H-1] ^ s1_bh_q[H-1]) & (s1_ah_q[H-1] ^ hi_sum[H-1]))
                       : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_bl_q    <= 1'b0;
            s1_comb_q  <= 1'b0;
            s1_tf_q    <= 1'b0;
            s1_c_q     <= '0;
            s1_ah_q    <= '0;
            s1_bh_q    <= '0;
            s1_cl_q    <= 1'b0;
            s1_zl_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_bl_q    <= 1'b0;
            s2_comb_q  <= 1'b0;
            s2_tf_q    <= 1'b0;
            s2_c_q     <= '0;
            s2_acc_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bl_q    <= s1_bl_d;
            s1_comb_q  <= s1_comb_d;
            s1_tf_q    <= s1_tf_d;
            s1_c_q     <= s1_c_d;
            s1_ah_q    <= s1_ah_d;
            s1_bh_q    <= s1_bh_d;
            s1_cl_q    <= s1_cl_d;
            s1_zl_q    <= s1_zl_d;
            s2_valid_q <= s2_valid_d;
            s2_bl_q    <= s2_bl_d;
            s2_comb_q  <= s2_comb_d;
            s2_tf_q    <= s2_tf_d;
            s2_c_q     <= s2_c_d;
            s2_acc_q   <= s2_acc_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.BL        = s2_bl_q;
    assign bus.COMB      = s2_comb_q;
    assign bus.COMB_TF   = s2_tf_q;
    assign bus.C         = s2_c_q;
    assign bus.ACC       = s2_acc_q;
    assign bus.busy      = s1_valid_q | s2_valid_q;

endmodule
